// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller:
// operation encodings, FSM state encoding, lane widths and op classifiers.
package dm_pkg;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } dm_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } dm_state_e;

  function automatic logic is_word(input dm_op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_half(input dm_op_e op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_load(input dm_op_e op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Combinational lane logic for the data-memory controller.
//   i_op     : captured operation
//   i_lane   : byte offset within the word (addr[1:0])
//   i_rd     : memory word (live read data or latched RMW word)
//   i_wdata  : store data
//   o_ld     : selected and sign/zero-extended load data
//   o_merge  : i_rd with the addressed byte/half replaced by store data
module dm_lane_unit
  import dm_pkg::*;
(
  input  dm_op_e            i_op,
  input  logic [1:0]        i_lane,
  input  logic [WORD_W-1:0] i_rd,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_ld,
  output logic [WORD_W-1:0] o_merge
);

  logic [BYTE_W-1:0] w_byte;
  logic [HALF_W-1:0] w_half;

  // Little-endian lanes: byte n at [8n+7:8n], half 1 at [31:16].
  assign w_byte = i_rd[{i_lane, 3'b000} +: BYTE_W];
  assign w_half = i_rd[{i_lane[1], 4'b0000} +: HALF_W];

  always_comb begin
    o_ld = '0;
    case (i_op)
      OP_LW:   o_ld = i_rd;
      OP_LH:   o_ld = {{(WORD_W-HALF_W){w_half[HALF_W-1]}}, w_half};
      OP_LHU:  o_ld = {{(WORD_W-HALF_W){1'b0}}, w_half};
      OP_LB:   o_ld = {{(WORD_W-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
      OP_LBU:  o_ld = {{(WORD_W-BYTE_W){1'b0}}, w_byte};
      default: o_ld = '0;
    endcase
  end

  always_comb begin
    o_merge = i_rd;
    case (i_op)
      OP_SH:   o_merge[{i_lane[1], 4'b0000} +: HALF_W] = i_wdata[HALF_W-1:0];
      OP_SB:   o_merge[{i_lane, 3'b000} +: BYTE_W]     = i_wdata[BYTE_W-1:0];
      default: o_merge = i_rd;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: accepts one load/store request at a time,
// checks alignment and range, drives a word-addressed memory, and returns
// extended load data or an exception flag via a valid/ready response.
//   clk, reset             : clock, async active-high reset
//   req_*                  : request handshake (op, byte addr, wdata, pc)
//   resp_*                 : response handshake (rdata, exc)
//   DMReadEN/DMWriteEN     : memory strobes
//   Addr, DM_WD, Pc        : word address, write data, pc to memory
//   DM_RD                  : combinational memory read data
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic        DMWriteEN,
  output logic        DMReadEN,
  output logic [31:0] Addr,
  output logic [31:0] DM_WD,
  output logic [31:0] Pc,
  input  logic [31:0] DM_RD
);

  dm_state_e   r_state, w_next;
  dm_op_e      r_op;
  logic [31:0] r_addr, r_wdata, r_pc, r_word, r_rdata;
  logic        r_exc;

  dm_op_e      w_req_op;
  logic        w_exc, w_accept;
  logic [31:0] w_lane_rd, w_ld, w_merge;

  assign w_req_op = dm_op_e'(req_op);
  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_exc    = (is_word(w_req_op) && (req_addr[1:0] != 2'b00)) ||
                    (is_half(w_req_op) && req_addr[0]) ||
                    (req_addr >= ADDR_LIMIT);

  // Merge works from the word latched in RMW_RD; loads use live read data.
  assign w_lane_rd = (r_state == ST_RMW_WR) ? r_word : DM_RD;

  dm_lane_unit u_lane (
    .i_op    (r_op),
    .i_lane  (r_addr[1:0]),
    .i_rd    (w_lane_rd),
    .i_wdata (r_wdata),
    .o_ld    (w_ld),
    .o_merge (w_merge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    DMReadEN   = 1'b0;
    DMWriteEN  = 1'b0;
    DM_WD      = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_exc)                  w_next = ST_RESP;
          else if (is_load(w_req_op)) w_next = ST_LOAD;
          else if (w_req_op == OP_SW) w_next = ST_STORE;
          else                        w_next = ST_RMW_RD;
        end
      end
      ST_LOAD: begin
        DMReadEN = 1'b1;
        w_next   = ST_RESP;
      end
      ST_STORE: begin
        DMWriteEN = 1'b1;
        DM_WD     = r_wdata;
        w_next    = ST_RESP;
      end
      ST_RMW_RD: begin
        DMReadEN = 1'b1;
        w_next   = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        DMWriteEN = 1'b1;
        DM_WD     = w_merge;
        w_next    = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op    <= OP_LW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_word  <= '0;
      r_rdata <= '0;
      r_exc   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= w_req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_pc    <= req_pc;
        r_rdata <= '0;
        r_exc   <= w_exc;
      end
      if (r_state == ST_LOAD)   r_rdata <= w_ld;
      if (r_state == ST_RMW_RD) r_word  <= DM_RD;
    end
  end

  assign Addr       = {r_addr[31:2], 2'b00};
  assign Pc         = r_pc;
  assign resp_rdata = r_rdata;
  assign resp_exc   = r_exc;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios followed by
// random traffic, checked against a byte-array reference of memory.
module tb_dm_access_ctrl;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, resp_ready = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic        req_ready, resp_valid, resp_exc, DMWriteEN, DMReadEN;
  logic [31:0] resp_rdata, Addr, DM_WD, Pc, DM_RD;

  dm_access_ctrl #(.ADDR_LIMIT(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .DMWriteEN(DMWriteEN), .DMReadEN(DMReadEN),
    .Addr(Addr), .DM_WD(DM_WD), .Pc(Pc), .DM_RD(DM_RD)
  );

  always #5 clk = ~clk;

  // Word memory seen by the DUT.
  logic [31:0] mem [0:4095];
  assign DM_RD = mem[Addr[13:2]];

  // Reference: plain byte array.
  logic [7:0] rb [0:16383];

  int wr_cnt = 0, rd_cnt = 0, wd_bad = 0;
  logic [31:0] last_wa = '0, last_wd = '0;

  always @(posedge clk) begin
    if (DMWriteEN) begin
      mem[Addr[13:2]] <= DM_WD;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= Addr;
      last_wd <= DM_WD;
    end
    if (DMReadEN) rd_cnt <= rd_cnt + 1;
    if (!DMWriteEN && DM_WD != 32'h0) wd_bad <= wd_bad + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"},   {31'b0, req_ready},  32'd1);
    chk({tag, "_rv"},    {31'b0, resp_valid}, 32'd0);
    chk({tag, "_rd"},    resp_rdata,          32'd0);
    chk({tag, "_exc"},   {31'b0, resp_exc},   32'd0);
    chk({tag, "_ren"},   {31'b0, DMReadEN},   32'd0);
    chk({tag, "_wen"},   {31'b0, DMWriteEN},  32'd0);
    chk({tag, "_addr"},  Addr,                32'd0);
    chk({tag, "_wd"},    DM_WD,               32'd0);
    chk({tag, "_pc"},    Pc,                  32'd0);
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [13:0] b;
    b = {a[13:2], 2'b00};
    return {rb[b+3], rb[b+2], rb[b+1], rb[b]};
  endfunction

  // Drives one request and checks its whole lifetime.
  task automatic xact(input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input int stall);
    logic        exc, ld, st;
    logic [31:0] exp_rd, exp_wd, hv, bv, pc;
    int          exp_lat, exp_rds, exp_wrs, lat, wr0, rd0, bnd;
    logic [13:0] ai;
    ai  = a[13:0];
    pc  = $urandom;
    ld  = (op <= 3'd4);
    st  = !ld;
    exc = (a >= 32'h3000) ||
          ((op == 3'd0 || op == 3'd5) && a[1:0] != 2'b00) ||
          ((op == 3'd1 || op == 3'd2 || op == 3'd6) && a[0]);
    hv  = {16'h0, rb[ai+1], rb[ai]};
    bv  = {24'h0, rb[ai]};
    exp_rd = 32'h0;
    if (!exc) begin
      case (op)
        3'd0: exp_rd = {rb[ai+3], rb[ai+2], rb[ai+1], rb[ai]};
        3'd1: exp_rd = hv[15] ? (hv | 32'hFFFF_0000) : hv;
        3'd2: exp_rd = hv;
        3'd3: exp_rd = bv[7] ? (bv | 32'hFFFF_FF00) : bv;
        3'd4: exp_rd = bv;
        3'd5: begin rb[ai] = wd[7:0]; rb[ai+1] = wd[15:8]; rb[ai+2] = wd[23:16]; rb[ai+3] = wd[31:24]; end
        3'd6: begin rb[ai] = wd[7:0]; rb[ai+1] = wd[15:8]; end
        default: rb[ai] = wd[7:0];
      endcase
    end
    exp_wd  = ref_word(a);
    exp_lat = exc ? 1 : (op >= 3'd6 ? 3 : 2);
    exp_rds = (exc || op == 3'd5) ? 0 : 1;
    exp_wrs = (!exc && st) ? 1 : 0;

    bnd = 0;
    while (!req_ready && bnd < 20) begin @(posedge clk); #1; bnd++; end
    chk("req_ready_wait", {31'b0, req_ready}, 32'd1);
    wr0 = wr_cnt; rd0 = rd_cnt;
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd; req_pc = pc;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = $urandom; req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      chk("busy_rdy", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rdata",   resp_rdata, exp_rd);
    chk("exc",     {31'b0, resp_exc}, {31'b0, exc});
    chk("addr",    Addr, {a[31:2], 2'b00});
    chk("pc",      Pc, pc);
    chk("rd_pulses", rd_cnt - rd0, exp_rds);
    chk("wr_pulses", wr_cnt - wr0, exp_wrs);
    if (exp_wrs == 1) begin
      chk("wr_addr", last_wa, {a[31:2], 2'b00});
      chk("wr_data", last_wd, exp_wd);
    end
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_rv",  {31'b0, resp_valid}, 32'd1);
      chk("stall_rd",  resp_rdata, exp_rd);
      chk("stall_exc", {31'b0, resp_exc}, {31'b0, exc});
      chk("stall_rdy", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("post_rv",  {31'b0, resp_valid}, 32'd0);
    chk("post_rdy", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int wr0;
    logic [31:0] a;
    logic [2:0]  op;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16384; i++) rb[i] = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst0");
    reset = 1'b0;

    // Word store then load.
    xact(OP_SW, 32'h10, 32'hDEADBEEF, 0);
    chk("mem_w10", mem[4], 32'hDEADBEEF);
    xact(OP_LW, 32'h10, 32'h0, 0);
    // Byte RMW and byte loads.
    xact(OP_SB, 32'h12, 32'h0000_0055, 0);
    chk("mem_sb", mem[4], 32'hDE55BEEF);
    xact(OP_LB,  32'h12, 32'h0, 0);
    xact(OP_LBU, 32'h13, 32'h0, 0);
    // Half loads with sign behaviour.
    xact(OP_SW,  32'h10, 32'h8000_7FFF, 0);
    xact(OP_LH,  32'h10, 32'h0, 0);
    xact(OP_LH,  32'h12, 32'h0, 0);
    xact(OP_LHU, 32'h12, 32'h0, 0);
    xact(OP_SH,  32'h12, 32'hAAAA_1234, 0);
    // Exceptions.
    xact(OP_LW, 32'h11, 32'h0, 0);
    xact(OP_SW, 32'h3000, 32'h1234_5678, 0);
    xact(OP_SH, 32'h21, 32'h1234_5678, 0);
    xact(OP_LB, 32'h2FFF, 32'h0, 0);
    // Response back-pressure.
    xact(OP_LW, 32'h10, 32'h0, 3);

    // Reset in the middle of an RMW.
    xact(OP_SW, 32'h14, 32'h1122_3344, 0);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h15; req_wdata = 32'hFF; req_pc = 32'h400;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_rd_ren", {31'b0, DMReadEN}, 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid_nowr", wr_cnt - wr0, 32'd0);
    chk("rst_mid_mem", mem[5], 32'h1122_3344);
    reset = 1'b0;
    xact(OP_LW, 32'h14, 32'h0, 0);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = $urandom_range(32'h2FF8, 32'h3FFF);
      else begin
        a = $urandom_range(0, 32'h3F);
        if ($urandom_range(0, 3) != 0) begin
          if (op == OP_LW || op == OP_SW) a[1:0] = 2'b00;
          else if (op == OP_LH || op == OP_LHU || op == OP_SH) a[0] = 1'b0;
        end
      end
      xact(op, a, $urandom, $urandom_range(0, 2));
    end

    for (int w = 0; w < 16; w++) chk("final_mem", mem[w], ref_word(32'(w * 4)));
    chk("wd_idle_zero", wd_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
